// File: rtl/pipeline_stall_sequencer.sv
// Stall/flush sequencer: turns hazard requests into PC, IF/ID, ID/EX and EX/MEM controls.
// Ports: Clk/Rst_n, hazard requests in, register controls + seq_state out; STALL_STATS_EN adds counters.
module pipeline_stall_sequencer #(
  parameter int MULDIV_LAT     = 32,
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = 6
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        load_use_haz,
  input  logic        branch_taken,
  input  logic        muldiv_start,
  input  logic        muldiv_done,
  input  logic        dmem_busy,
  output logic        PC_write,
  output logic        IFID_write,
  output logic        IFID_flush,
  output logic        IDEX_bubble,
  output logic        IDEX_hold,
  output logic        pipe_freeze,
  output logic [1:0]  seq_state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] BR_LOAD =
    (BRANCH_PENALTY > 1) ? CNT_W'(BRANCH_PENALTY - 2) : '0;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pc_w, ifid_w, flush, bub, hold, frz, br_acc;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_w    = 1'b0;
    ifid_w  = 1'b0;
    flush   = 1'b0;
    bub     = 1'b0;
    hold    = 1'b0;
    frz     = 1'b0;
    br_acc  = 1'b0;
    if (dmem_busy) begin
      // memory wait freezes everything, sequence included
      hold = 1'b1;
      frz  = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          pc_w   = 1'b1;
          ifid_w = 1'b1;
          if (muldiv_start) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            cnt_d   = MD_LOAD;
            state_d = MD_WAIT;
          end else if (load_use_haz) begin
            // branch is re-presented after the stall
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            bub    = 1'b1;
          end else if (branch_taken) begin
            flush  = 1'b1;
            br_acc = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              cnt_d   = BR_LOAD;
              state_d = FLUSH;
            end
          end
        end
        MD_WAIT: begin
          hold = 1'b1;
          // start cycle counts toward the latency, so leave at 1
          if (muldiv_done || cnt_q <= ONE) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        FLUSH: begin
          pc_w   = 1'b1;
          ifid_w = 1'b1;
          flush  = 1'b1;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign PC_write    = Rst_n & pc_w;
  assign IFID_write  = Rst_n & ifid_w;
  assign IFID_flush  = Rst_n & flush;
  assign IDEX_bubble = Rst_n & bub;
  assign IDEX_hold   = Rst_n & hold;
  assign pipe_freeze = Rst_n & frz;
  assign seq_state   = state_q;

`ifdef STALL_STATS_EN
  logic [31:0] stall_q, fcnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_q <= '0;
      fcnt_q  <= '0;
    end else begin
      if (!pc_w) stall_q <= stall_q + 32'd1;
      if (br_acc) fcnt_q <= fcnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = fcnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed bench for pipeline_stall_sequencer (MULDIV_LAT=4, BRANCH_PENALTY=3).
// Control vector = {PC_write,IFID_write,IFID_flush,IDEX_bubble,IDEX_hold,pipe_freeze,seq_state}.
module tb_pipeline_stall_sequencer;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        load_use_haz, branch_taken, muldiv_start, muldiv_done, dmem_busy;
  logic        PC_write, IFID_write, IFID_flush, IDEX_bubble, IDEX_hold, pipe_freeze;
  logic [1:0]  seq_state;
  logic [31:0] stall_cycles, flush_count;

  int tests = 0;
  int fails = 0;

`ifdef STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [7:0] V_RST  = 8'b0000_0000;
  localparam logic [7:0] V_IDLE = 8'b1100_0000;
  localparam logic [7:0] V_LU   = 8'b0001_0000;
  localparam logic [7:0] V_MDS  = 8'b0000_0000;
  localparam logic [7:0] V_MDW  = 8'b0000_1001;
  localparam logic [7:0] V_MDB  = 8'b0000_1101;
  localparam logic [7:0] V_RNB  = 8'b0000_1100;
  localparam logic [7:0] V_BR   = 8'b1110_0000;
  localparam logic [7:0] V_FL   = 8'b1110_0010;

  pipeline_stall_sequencer #(
    .MULDIV_LAT    (4),
    .BRANCH_PENALTY(3),
    .CNT_W         (6)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .load_use_haz(load_use_haz),
    .branch_taken(branch_taken),
    .muldiv_start(muldiv_start),
    .muldiv_done (muldiv_done),
    .dmem_busy   (dmem_busy),
    .PC_write    (PC_write),
    .IFID_write  (IFID_write),
    .IFID_flush  (IFID_flush),
    .IDEX_bubble (IDEX_bubble),
    .IDEX_hold   (IDEX_hold),
    .pipe_freeze (pipe_freeze),
    .seq_state   (seq_state),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive one cycle's inputs at the falling edge, check outputs 1ns later
  task automatic cyc(input logic rst, input logic lu, input logic br,
                     input logic ms, input logic md, input logic busy,
                     input logic [7:0] exp, input string tag);
    logic [7:0] obs;
    @(negedge Clk);
    Rst_n        = rst;
    load_use_haz = lu;
    branch_taken = br;
    muldiv_start = ms;
    muldiv_done  = md;
    dmem_busy    = busy;
    #1;
    obs = {PC_write, IFID_write, IFID_flush, IDEX_bubble,
           IDEX_hold, pipe_freeze, seq_state};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    Rst_n        = 1'b0;
    load_use_haz = 1'b0;
    branch_taken = 1'b0;
    muldiv_start = 1'b0;
    muldiv_done  = 1'b0;
    dmem_busy    = 1'b0;

    cyc(0, 0, 1, 0, 0, 0, V_RST, "rst_br");
    cyc(0, 0, 0, 1, 0, 0, V_RST, "rst_md");
    chk32("rst_stall", stall_cycles, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, V_IDLE, "idle");

    cyc(1, 1, 1, 0, 0, 0, V_LU, "lu");
    cyc(1, 0, 0, 0, 0, 0, V_IDLE, "lu_after");

    cyc(1, 0, 0, 1, 0, 0, V_MDS, "md_start");
    cyc(1, 1, 1, 0, 0, 0, V_MDW, "md1");
    cyc(1, 0, 0, 0, 0, 0, V_MDW, "md2");
    cyc(1, 0, 0, 0, 0, 0, V_MDW, "md3");
    cyc(1, 0, 0, 0, 0, 0, V_IDLE, "md_end");

    cyc(1, 0, 0, 1, 0, 0, V_MDS, "dn_start");
    cyc(1, 0, 0, 0, 0, 0, V_MDW, "dn1");
    cyc(1, 0, 0, 0, 1, 0, V_MDW, "dn2");
    cyc(1, 0, 0, 0, 0, 0, V_IDLE, "dn_end");

    cyc(1, 0, 1, 0, 0, 0, V_BR, "br0");
    cyc(1, 0, 1, 0, 0, 0, V_FL, "br1");
    cyc(1, 0, 0, 0, 0, 0, V_FL, "br2");
    cyc(1, 0, 0, 0, 0, 0, V_IDLE, "br_end");
    chk32("flush_count", flush_count, STATS ? 32'd1 : 32'd0);

    cyc(1, 0, 0, 1, 0, 0, V_MDS, "bz_start");
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, 0, 0, 1, V_MDB, "bz_freeze");
    cyc(1, 0, 0, 0, 0, 0, V_MDW, "bz_md1");
    cyc(1, 0, 0, 0, 0, 0, V_MDW, "bz_md2");
    cyc(1, 0, 0, 0, 0, 0, V_MDW, "bz_md3");
    cyc(1, 0, 0, 0, 0, 0, V_IDLE, "bz_end");
    chk32("stall_cycles", stall_cycles, STATS ? 32'd17 : 32'd0);

    cyc(1, 0, 1, 1, 0, 1, V_RNB, "busy_run");
    cyc(1, 0, 0, 0, 0, 0, V_IDLE, "busy_run_end");
    chk32("flush_hold", flush_count, STATS ? 32'd1 : 32'd0);

    cyc(1, 1, 0, 1, 0, 0, V_MDS, "prio_start");
    cyc(1, 0, 0, 0, 0, 0, V_MDW, "prio_md1");
    cyc(0, 0, 0, 0, 0, 0, V_RST, "rst_mid");
    chk32("rst_mid_stall", stall_cycles, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, V_IDLE, "rst_rel");
    cyc(1, 0, 0, 0, 0, 0, V_IDLE, "rst_rel2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
